// File: rtl/scoreboard_pkg.sv
// Shared encodings for the volleyball scorekeeper: FSM states, team indices
// and the common width used for targets and lead thresholds.
package scoreboard_pkg;

   typedef enum logic [1:0] {
      PLAY       = 2'd0,
      SET_END    = 2'd1,
      MATCH_OVER = 2'd2
   } state_e;

   localparam logic TEAM_A = 1'b0;
   localparam logic TEAM_B = 1'b1;

   // Targets and leads are carried at this width so any PTS_W below it compares cleanly.
   localparam int TGT_W = 16;

endpackage

// File: rtl/set_win_check.sv
// Combinational set-closing test: a team wins the set when it has reached the
// target and leads by at least min_lead, with the lead taken as a signed difference.
module set_win_check
   import scoreboard_pkg::*;
#(
   parameter int PTS_W = 6
) (
   input  logic [PTS_W-1:0] pts_a,
   input  logic [PTS_W-1:0] pts_b,
   input  logic [TGT_W-1:0] target,
   input  logic [TGT_W-1:0] min_lead,
   output logic             win_a,
   output logic             win_b
);

   logic signed [PTS_W:0] lead_a_s;
   logic signed [PTS_W:0] lead_b_s;
   logic signed [TGT_W:0] lead_a_ext_s;
   logic signed [TGT_W:0] lead_b_ext_s;
   logic signed [TGT_W:0] min_lead_s;
   logic [TGT_W-1:0]      pts_a_ext_s;
   logic [TGT_W-1:0]      pts_b_ext_s;

   // One extra bit keeps a trailing team's lead negative instead of wrapping.
   assign lead_a_s     = $signed({1'b0, pts_a}) - $signed({1'b0, pts_b});
   assign lead_b_s     = $signed({1'b0, pts_b}) - $signed({1'b0, pts_a});
   assign lead_a_ext_s = $signed({{(TGT_W-PTS_W){lead_a_s[PTS_W]}}, lead_a_s});
   assign lead_b_ext_s = $signed({{(TGT_W-PTS_W){lead_b_s[PTS_W]}}, lead_b_s});
   assign min_lead_s   = $signed({1'b0, min_lead});
   assign pts_a_ext_s  = {{(TGT_W-PTS_W){1'b0}}, pts_a};
   assign pts_b_ext_s  = {{(TGT_W-PTS_W){1'b0}}, pts_b};

   assign win_a = (pts_a_ext_s >= target) && (lead_a_ext_s >= min_lead_s);
   assign win_b = (pts_b_ext_s >= target) && (lead_b_ext_s >= min_lead_s);

endmodule

// File: rtl/set_match_tracker.sv
// Two-team volleyball match scorekeeper: rally points, win-by-lead set closing,
// set tally, latched match result and a single-level undo of the last point.
module set_match_tracker
   import scoreboard_pkg::*;
#(
   parameter int PTS_W          = 6,
   parameter int SET_W          = 2,
   parameter int SETS_TO_WIN    = 3,
   parameter int SET_TARGET     = 25,
   parameter int DECIDER_TARGET = 15,
   parameter int MIN_LEAD       = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             point_a,
   input  logic             point_b,
   input  logic             undo,
   input  logic             next_set,
   output logic [PTS_W-1:0] pts_a,
   output logic [PTS_W-1:0] pts_b,
   output logic [SET_W-1:0] sets_a,
   output logic [SET_W-1:0] sets_b,
   output logic             set_won_a,
   output logic             set_won_b,
   output logic             match_over,
   output logic             winner,
   output logic             conflict,
   output logic [1:0]       state
);

   localparam logic [PTS_W-1:0] PTS_MAX      = {PTS_W{1'b1}};
   localparam logic [SET_W:0]   DECIDER_SETS = (SET_W+1)'(2*SETS_TO_WIN-2);
   localparam logic [SET_W-1:0] SETS_WIN     = SET_W'(SETS_TO_WIN);
   localparam logic [TGT_W-1:0] SET_TGT      = TGT_W'(SET_TARGET);
   localparam logic [TGT_W-1:0] DEC_TGT      = TGT_W'(DECIDER_TARGET);
   localparam logic [TGT_W-1:0] LEAD_TGT     = TGT_W'(MIN_LEAD);

   state_e           state_q, state_d;
   logic [PTS_W-1:0] pts_a_q, pts_a_d, pts_b_q, pts_b_d;
   logic [SET_W-1:0] sets_a_q, sets_a_d, sets_b_q, sets_b_d;
   logic             set_won_a_q, set_won_a_d, set_won_b_q, set_won_b_d;
   logic             match_over_q, match_over_d, winner_q, winner_d;
   logic             conflict_q, conflict_d;
   logic             hist_valid_q, hist_valid_d, hist_team_q, hist_team_d;

   logic [PTS_W-1:0] pts_a_nx_s, pts_b_nx_s;
   logic             accept_s;
   logic [SET_W:0]   sets_sum_s;
   logic [TGT_W-1:0] target_s;
   logic             win_a_s, win_b_s;

   // Candidate counts if the pending single point is accepted (dropped at saturation).
   always_comb begin
      pts_a_nx_s = pts_a_q;
      pts_b_nx_s = pts_b_q;
      accept_s   = 1'b0;
      if (point_a && !point_b && (pts_a_q != PTS_MAX)) begin
         pts_a_nx_s = pts_a_q + PTS_W'(1);
         accept_s   = 1'b1;
      end else if (point_b && !point_a && (pts_b_q != PTS_MAX)) begin
         pts_b_nx_s = pts_b_q + PTS_W'(1);
         accept_s   = 1'b1;
      end else begin
         accept_s   = 1'b0;
      end
   end

   assign sets_sum_s = {1'b0, sets_a_q} + {1'b0, sets_b_q};
   assign target_s   = (sets_sum_s == DECIDER_SETS) ? DEC_TGT : SET_TGT;

   set_win_check #(.PTS_W(PTS_W)) u_win_check (
      .pts_a    (pts_a_nx_s),
      .pts_b    (pts_b_nx_s),
      .target   (target_s),
      .min_lead (LEAD_TGT),
      .win_a    (win_a_s),
      .win_b    (win_b_s)
   );

   // Next-state logic; undo outranks every other input in every state.
   always_comb begin
      state_d      = state_q;
      pts_a_d      = pts_a_q;
      pts_b_d      = pts_b_q;
      sets_a_d     = sets_a_q;
      sets_b_d     = sets_b_q;
      set_won_a_d  = 1'b0;
      set_won_b_d  = 1'b0;
      match_over_d = match_over_q;
      winner_d     = winner_q;
      conflict_d   = 1'b0;
      hist_valid_d = hist_valid_q;
      hist_team_d  = hist_team_q;
      if (undo) begin
         if (hist_valid_q) begin
            if (hist_team_q == TEAM_B) begin
               pts_b_d = pts_b_q - PTS_W'(1);
            end else begin
               pts_a_d = pts_a_q - PTS_W'(1);
            end
            if (state_q != PLAY) begin
               if (hist_team_q == TEAM_B) begin
                  sets_b_d = sets_b_q - SET_W'(1);
               end else begin
                  sets_a_d = sets_a_q - SET_W'(1);
               end
               state_d      = PLAY;
               match_over_d = 1'b0;
               winner_d     = 1'b0;
            end else begin
               state_d = state_q;
            end
            hist_valid_d = 1'b0;
         end else begin
            hist_valid_d = hist_valid_q;
         end
      end else begin
         case (state_q)
            PLAY: begin
               if (point_a && point_b) begin
                  conflict_d = 1'b1;
               end else if (point_a || point_b) begin
                  pts_a_d = pts_a_nx_s;
                  pts_b_d = pts_b_nx_s;
                  if (accept_s) begin
                     hist_valid_d = 1'b1;
                     hist_team_d  = point_b ? TEAM_B : TEAM_A;
                  end else begin
                     hist_valid_d = hist_valid_q;
                  end
                  if (point_a && win_a_s) begin
                     sets_a_d    = sets_a_q + SET_W'(1);
                     set_won_a_d = 1'b1;
                     if ((sets_a_q + SET_W'(1)) == SETS_WIN) begin
                        state_d      = MATCH_OVER;
                        match_over_d = 1'b1;
                        winner_d     = TEAM_A;
                     end else begin
                        state_d = SET_END;
                     end
                  end else if (point_b && win_b_s) begin
                     sets_b_d    = sets_b_q + SET_W'(1);
                     set_won_b_d = 1'b1;
                     if ((sets_b_q + SET_W'(1)) == SETS_WIN) begin
                        state_d      = MATCH_OVER;
                        match_over_d = 1'b1;
                        winner_d     = TEAM_B;
                     end else begin
                        state_d = SET_END;
                     end
                  end else begin
                     state_d = PLAY;
                  end
               end else begin
                  state_d = PLAY;
               end
            end
            SET_END: begin
               if (next_set) begin
                  pts_a_d      = '0;
                  pts_b_d      = '0;
                  hist_valid_d = 1'b0;
                  state_d      = PLAY;
               end else begin
                  state_d = SET_END;
               end
            end
            MATCH_OVER: begin
               state_d = MATCH_OVER;
            end
            default: begin
               state_d = PLAY;
            end
         endcase
      end
   end

   // State, counters, pulses and history registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= PLAY;
         pts_a_q      <= '0;
         pts_b_q      <= '0;
         sets_a_q     <= '0;
         sets_b_q     <= '0;
         set_won_a_q  <= 1'b0;
         set_won_b_q  <= 1'b0;
         match_over_q <= 1'b0;
         winner_q     <= 1'b0;
         conflict_q   <= 1'b0;
         hist_valid_q <= 1'b0;
         hist_team_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pts_a_q      <= pts_a_d;
         pts_b_q      <= pts_b_d;
         sets_a_q     <= sets_a_d;
         sets_b_q     <= sets_b_d;
         set_won_a_q  <= set_won_a_d;
         set_won_b_q  <= set_won_b_d;
         match_over_q <= match_over_d;
         winner_q     <= winner_d;
         conflict_q   <= conflict_d;
         hist_valid_q <= hist_valid_d;
         hist_team_q  <= hist_team_d;
      end
   end

   assign pts_a      = pts_a_q;
   assign pts_b      = pts_b_q;
   assign sets_a     = sets_a_q;
   assign sets_b     = sets_b_q;
   assign set_won_a  = set_won_a_q;
   assign set_won_b  = set_won_b_q;
   assign match_over = match_over_q;
   assign winner     = winner_q;
   assign conflict   = conflict_q;
   assign state      = state_q;

endmodule

// File: tb/tb_set_match_tracker.sv
// Directed bench: default-parameter tracker for sets, deuce, decider and undo,
// plus a PTS_W=3 tracker for point saturation.
module tb_set_match_tracker;

   logic       clk, rst;
   logic       point_a, point_b, undo, next_set;
   logic [5:0] pts_a, pts_b;
   logic [1:0] sets_a, sets_b, state;
   logic       set_won_a, set_won_b, match_over, winner, conflict;

   logic       p2_a, p2_b, undo2, next_set2;
   logic [2:0] pts_a2, pts_b2;
   logic [1:0] sets_a2, sets_b2, state2;
   logic       set_won_a2, set_won_b2, match_over2, winner2, conflict2;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic pa, pb, u, ns;
      int   epa, epb, esa, esb;
      logic ewa, ewb, emo, ew, ec;
      int   est;
   } vec_t;

   vec_t tbl[12];

   set_match_tracker dut (
      .clk(clk), .rst(rst), .point_a(point_a), .point_b(point_b), .undo(undo),
      .next_set(next_set), .pts_a(pts_a), .pts_b(pts_b), .sets_a(sets_a), .sets_b(sets_b),
      .set_won_a(set_won_a), .set_won_b(set_won_b), .match_over(match_over),
      .winner(winner), .conflict(conflict), .state(state)
   );

   set_match_tracker #(.PTS_W(3), .SET_W(2), .SETS_TO_WIN(3), .SET_TARGET(10),
                       .DECIDER_TARGET(10), .MIN_LEAD(2)) dut_sat (
      .clk(clk), .rst(rst), .point_a(p2_a), .point_b(p2_b), .undo(undo2),
      .next_set(next_set2), .pts_a(pts_a2), .pts_b(pts_b2), .sets_a(sets_a2), .sets_b(sets_b2),
      .set_won_a(set_won_a2), .set_won_b(set_won_b2), .match_over(match_over2),
      .winner(winner2), .conflict(conflict2), .state(state2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pk(input int pa, input int pb, input int sa, input int sb,
                                      input logic wa, input logic wb, input logic mo,
                                      input logic w, input logic c, input int st);
      logic [5:0] a6, b6;
      logic [1:0] sa2, sb2, st2;
      a6 = pa[5:0]; b6 = pb[5:0]; sa2 = sa[1:0]; sb2 = sb[1:0]; st2 = st[1:0];
      return {9'd0, a6, b6, sa2, sb2, wa, wb, mo, w, c, st2};
   endfunction

   function automatic logic [31:0] act();
      return pk(int'(pts_a), int'(pts_b), int'(sets_a), int'(sets_b),
                set_won_a, set_won_b, match_over, winner, conflict, int'(state));
   endfunction

   function automatic logic [31:0] act2();
      return {20'd0, pts_a2, pts_b2, sets_a2, sets_b2, state2};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step(input logic pa, input logic pb, input logic u, input logic ns);
      point_a = pa; point_b = pb; undo = u; next_set = ns;
      @(posedge clk); #1;
      point_a = 1'b0; point_b = 1'b0; undo = 1'b0; next_set = 1'b0;
   endtask

   task automatic step2(input logic pa, input logic pb, input logic u);
      p2_a = pa; p2_b = pb; undo2 = u;
      @(posedge clk); #1;
      p2_a = 1'b0; p2_b = 1'b0; undo2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clk = 1'b0; rst = 1'b1;
      point_a = 1'b0; point_b = 1'b0; undo = 1'b0; next_set = 1'b0;
      p2_a = 1'b0; p2_b = 1'b0; undo2 = 1'b0; next_set2 = 1'b0;

      // Deuce continuation from 24-24 with sets 1-0.
      tbl[0]  = '{1'b1,1'b1,1'b0,1'b0, 24,24,1,0, 1'b0,1'b0,1'b0,1'b0,1'b1, 0};
      tbl[1]  = '{1'b1,1'b0,1'b0,1'b0, 25,24,1,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0};
      tbl[2]  = '{1'b0,1'b1,1'b1,1'b0, 24,24,1,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0};
      tbl[3]  = '{1'b0,1'b0,1'b1,1'b0, 24,24,1,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0};
      tbl[4]  = '{1'b1,1'b0,1'b0,1'b0, 25,24,1,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0};
      tbl[5]  = '{1'b0,1'b1,1'b0,1'b0, 25,25,1,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0};
      tbl[6]  = '{1'b1,1'b0,1'b0,1'b0, 26,25,1,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0};
      tbl[7]  = '{1'b1,1'b0,1'b0,1'b0, 27,25,2,0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1};
      tbl[8]  = '{1'b0,1'b1,1'b0,1'b0, 27,25,2,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1};
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,  0, 0,2,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0};
      tbl[10] = '{1'b0,1'b0,1'b0,1'b1,  0, 0,2,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0};
      tbl[11] = '{1'b0,1'b0,1'b1,1'b0,  0, 0,2,0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", act(), 32'd0);
      chk("reset_state_sat", act2(), 32'd0);
      rst = 1'b0;

      // Set 1: A scores 25 straight.
      for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("set1_24_0", act(), pk(24,0,0,0,0,0,0,0,0,0));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("set1_close", act(), pk(25,0,1,0,1,0,0,0,0,1));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("set1_won_one_pulse", act(), pk(25,0,1,0,0,0,0,0,0,1));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("set1_point_in_set_end", act(), pk(25,0,1,0,0,0,0,0,0,1));
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("set1_next_set", act(), pk(0,0,1,0,0,0,0,0,0,0));

      // Set 2: deuce, conflict and undo handling from the table.
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("set2_24_24", act(), pk(24,24,1,0,0,0,0,0,0,0));
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].pa, tbl[i].pb, tbl[i].u, tbl[i].ns);
         chk($sformatf("vec%0d", i), act(),
             pk(tbl[i].epa, tbl[i].epb, tbl[i].esa, tbl[i].esb, tbl[i].ewa, tbl[i].ewb,
                tbl[i].emo, tbl[i].ew, tbl[i].ec, tbl[i].est));
      end

      // Set 3: B wins, undo across the set boundary, then wins again.
      for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("set3_close_b", act(), pk(0,25,2,1,0,1,0,0,0,1));
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("set3_undo_close", act(), pk(0,24,2,0,0,0,0,0,0,0));
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("set3_second_undo", act(), pk(0,24,2,0,0,0,0,0,0,0));
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("set3_reclose", act(), pk(0,25,2,1,0,1,0,0,0,1));
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Set 4: B wins, sets 2-2.
      for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("set4_close_b", act(), pk(0,25,2,2,0,1,0,0,0,1));
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Deciding set to 15 points.
      for (int i = 0; i < 13; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("dec_13_13", act(), pk(13,13,2,2,0,0,0,0,0,0));
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("dec_13_14_open", act(), pk(13,14,2,2,0,0,0,0,0,0));
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("dec_match_over", act(), pk(13,15,2,3,0,1,1,1,0,2));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("match_over_point_a", act(), pk(13,15,2,3,0,0,1,1,0,2));
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("match_over_next_set", act(), pk(13,15,2,3,0,0,1,1,0,2));
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("match_over_undo", act(), pk(13,14,2,2,0,0,0,0,0,0));
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("match_over_undo2", act(), pk(13,14,2,2,0,0,0,0,0,0));

      // Asynchronous reset in the middle of a point pulse.
      point_a = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      chk("rst_async", act(), 32'd0);
      @(posedge clk); #1;
      point_a = 1'b0;
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("first_point_after_rst", act(), pk(1,0,0,0,0,0,0,0,0,0));

      // Saturation on the narrow counter.
      for (int i = 0; i < 7; i++) step2(1'b1, 1'b0, 1'b0);
      chk("sat_reach_7", act2(), {20'd0, 3'd7, 3'd0, 2'd0, 2'd0, 2'd0});
      step2(1'b1, 1'b0, 1'b0);
      chk("sat_drop", act2(), {20'd0, 3'd7, 3'd0, 2'd0, 2'd0, 2'd0});
      step2(1'b0, 1'b0, 1'b1);
      chk("sat_undo_6", act2(), {20'd0, 3'd6, 3'd0, 2'd0, 2'd0, 2'd0});
      step2(1'b0, 1'b0, 1'b1);
      chk("sat_undo_again", act2(), {20'd0, 3'd6, 3'd0, 2'd0, 2'd0, 2'd0});
      step2(1'b0, 1'b1, 1'b0);
      chk("sat_point_b", act2(), {20'd0, 3'd6, 3'd1, 2'd0, 2'd0, 2'd0});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/set_match_tracker.md
# set_match_tracker

Parametrised two-team volleyball match scorekeeper. It counts rally points per team in the current set and applies the win-by-lead rule, with a separate target for the deciding set. It also keeps the set tally, latches the match result and supports a single-level undo. It sits between the debounced scoring buttons and the 7-segment display and LED drivers, and replaces the standalone per-team set counter.

## Interface
- PTS_W, 6: width of each point counter; counters saturate at 2^PTS_W-1.
- SET_W, 2: width of each set counter.
- SETS_TO_WIN, 3: sets needed to win the match. Must be ≤ 2^SET_W-1.
- SET_TARGET, 25: points needed to win a regular set.
- DECIDER_TARGET, 15: points needed to win the deciding set.
- MIN_LEAD, 2: minimum lead required to close a set.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- point_a / point_b, in, 1: one-cycle pulse; the team scored a rally.
- undo, in, 1: one-cycle pulse; retract the last accepted point.
- next_set, in, 1: one-cycle pulse; acknowledge a finished set and start the next.
- pts_a / pts_b, out, PTS_W: current set points.
- sets_a / sets_b, out, SET_W: sets won.
- set_won_a / set_won_b, out, 1: one-cycle pulse when a set closes.
- match_over, out, 1: level; the match is decided.
- winner, out, 1: 0 = A, 1 = B. Valid only while match_over is high.
- conflict, out, 1: one-cycle pulse when point_a and point_b arrive together.
- state, out, 2: 0 PLAY, 1 SET_END, 2 MATCH_OVER.

## Operation
- Reset: all outputs 0, state PLAY, history empty.
- The deciding set is active when sets_a + sets_b == 2·SETS_TO_WIN−2. Its target is DECIDER_TARGET; every other set uses SET_TARGET.
- PLAY, single point (point_x high, other point low, undo low):
  - If pts_x is below the maximum, pts_x increments. history ← {valid, x}.
  - If pts_x is at the maximum, the point is dropped and history is unchanged.
  - After the update, if new pts_x ≥ target and new pts_x − pts_other ≥ MIN_LEAD:
    - sets_x increments and set_won_x pulses.
    - If new sets_x == SETS_TO_WIN, go to MATCH_OVER with winner = x. Otherwise go to SET_END.
- PLAY with both point inputs high: no count change, conflict pulses.
- undo has priority over any point input arriving in the same cycle; those points are dropped and conflict does not pulse.
- undo with valid history, in any state:
  - pts_{history team} decrements.
  - If the state is SET_END or MATCH_OVER, sets_{history team} also decrements, match_over clears and the state returns to PLAY.
  - history is then cleared; only one level of undo is kept.
- undo with empty history: ignored.
- SET_END: points hold the final score for display. Point inputs are ignored. next_set clears both pts and history, then the state goes to PLAY.
- MATCH_OVER: absorbing. Only undo or rst leaves it. point_x and next_set are ignored.
- next_set outside SET_END: ignored.

## Timing
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N, with no pipeline beyond that.
- set_won_x is high for exactly the cycle after the closing-point edge. It appears in the same cycle as the updated pts, sets and state.
- Point inputs arriving in the cycle immediately after a set closes are ignored, because the state is already SET_END.
- rst asserted mid-set or mid-pulse clears everything immediately, asynchronously. The first point is accepted on the first edge after rst deasserts.
- Lead is computed as a signed (PTS_W+1)-bit difference, so there is no wrap-around. pts never underflows, because undo requires a prior increment.

## Structure
- Shared package scoreboard_pkg holds the state encodings (PLAY, SET_END, MATCH_OVER) and the team index constants (TEAM_A = 0, TEAM_B = 1).
- One sub-module, set_win_check (combinational): inputs are both point counts, the target and MIN_LEAD; output is the per-team win flags. It is instantiated once.
- The top level holds the FSM, the counters and the history register.

## Test plan
- Regular set: A scores 25 straight (B at 0). On the 25th point, set_won_a pulses once, sets_a = 1, state = SET_END. next_set → pts = 0/0, state PLAY.
- Deuce: bring the score to 24–24, then A, B, A, A. The set stays open at 25–24, 25–25 and 26–25, and closes at 27–25 with sets_a incremented.
- Decider: reach sets 2–2. B closes at 15–13 → match_over = 1, winner = 1, state MATCH_OVER. Further point_a, next_set → all counts unchanged.
- Undo across a set boundary:
  - Undo after the closing point → pts 24–x, sets decremented, state PLAY, set_won not re-pulsed.
  - A second undo → ignored.
- Concurrency:
  - point_a and point_b together → conflict pulse, no change.
  - undo and point_b together → undo only, no conflict.
  - point input in SET_END → ignored.
- Saturation and reset: with PTS_W = 3 and targets above 7, pts_a saturates at 7. Extra points are dropped and undo still restores 6. rst mid-pulse → all outputs 0.
